muldiv_ctrl: RTL and testbench

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

---
 rtl/muldiv_ctrl_if.sv | 28 ++
 rtl/muldiv_ctrl.sv | 142 ++++++++++++++
 tb/tb_muldiv_ctrl.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_ctrl_if.sv
// Bus between the pipeline E/D stages and the multiply/divide controller.
// The pipeline drives requests and operands. The controller returns its
// status, the HI/LO registers and the mfhi/mflo read data.
interface muldiv_ctrl_if;
   logic        start;
   logic        mult_E;
   logic        div_E;
   logic        mfhi_E;
   logic        mflo_E;
   logic [31:0] rs_E;
   logic [31:0] rt_E;
   logic        md_D;
   logic        busy;
   logic        stall_md;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] md_out;

   modport master (
      output start, mult_E, div_E, mfhi_E, mflo_E, rs_E, rt_E, md_D,
      input  busy, stall_md, hi, lo, md_out
   );

   modport slave (
      input  start, mult_E, div_E, mfhi_E, mflo_E, rs_E, rt_E, md_D,
      output busy, stall_md, hi, lo, md_out
   );
endinterface

// File: rtl/muldiv_ctrl.sv
// Multi-cycle multiply/divide controller for a MIPS-style pipeline.
// A launched mult or div latches its operands and then holds busy for a
// fixed number of cycles. The result is written into HI/LO on the final
// busy edge. While busy, any new start is ignored. mfhi/mflo read data is
// taken straight from the architectural HI/LO registers.
module muldiv_ctrl #(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input logic            clk,
   input logic            reset,
   muldiv_ctrl_if.slave   bus
);

   localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
   localparam int CNT_W   = ($clog2(MAX_CYC + 1) < 4) ? 4 : $clog2(MAX_CYC + 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MULT = 2'd1;
   localparam logic [1:0] DIV  = 2'd2;

   localparam logic [31:0] INT_MIN = 32'h8000_0000;
   localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      opA_q, opA_d;
   logic [31:0]      opB_q, opB_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;

   logic signed [63:0] product;
   logic signed [31:0] safeDivisor;
   logic [31:0]        quotient;
   logic [31:0]        remainder;
   logic               busy;
   logic               unusedMflo;

   assign busy       = (state_q != IDLE);
   assign unusedMflo = bus.mflo_E;

   // Arithmetic on the latched operands. The divide-by-zero case swaps in a
   // harmless divisor because the result is discarded anyway. INT_MIN / -1
   // is pinned explicitly so that the overflowing quotient wraps to INT_MIN
   // with a zero remainder.
   always_comb begin
      product     = $signed(opA_q) * $signed(opB_q);
      safeDivisor = (opB_q == 32'd0) ? 32'sd1 : $signed(opB_q);
      quotient    = 32'd0;
      remainder   = 32'd0;
      if ((opA_q == INT_MIN) && (opB_q == NEG_ONE)) begin
         quotient  = INT_MIN;
         remainder = 32'd0;
      end else begin
         quotient  = $signed(opA_q) / safeDivisor;
         remainder = $signed(opA_q) % safeDivisor;
      end
   end

   // Next-state logic: launch from IDLE, count down while busy, and commit
   // the result on the last busy cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      opA_d   = opA_q;
      opB_d   = opB_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         IDLE: begin
            if (bus.start && bus.mult_E) begin
               state_d = MULT;
               cnt_d   = CNT_W'(MULT_CYC);
               opA_d   = bus.rs_E;
               opB_d   = bus.rt_E;
            end else if (bus.start && bus.div_E) begin
               state_d = DIV;
               cnt_d   = CNT_W'(DIV_CYC);
               opA_d   = bus.rs_E;
               opB_d   = bus.rt_E;
            end
         end
         MULT: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = IDLE;
               cnt_d   = '0;
               hi_d    = product[63:32];
               lo_d    = product[31:0];
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DIV: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = IDLE;
               cnt_d   = '0;
               if (opB_q != 32'd0) begin
                  hi_d = remainder;
                  lo_d = quotient;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State registers. Reset clears everything, which also aborts any
   // operation in flight so no late result can land.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         opA_q   <= '0;
         opB_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         opA_q   <= opA_d;
         opB_q   <= opB_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   // Outputs. Read data and stall are combinational, so the hazard unit sees
   // a launching mult/div in the same cycle.
   always_comb begin
      bus.busy     = busy;
      bus.hi       = hi_q;
      bus.lo       = lo_q;
      bus.md_out   = bus.mfhi_E ? hi_q : lo_q;
      bus.stall_md = bus.md_D & (busy | bus.start);
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl. The bench has three parts:
// directed vectors with hand-computed results, multi-cycle corner sequences,
// and a randomized run checked against an arithmetic reference model.
module tb_muldiv_ctrl;

   localparam int MULT_CYC = 5;
   localparam int DIV_CYC  = 10;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   muldiv_ctrl_if bus();

   muldiv_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: remaining busy cycles plus a pending result computed
   // with 64-bit arithmetic when an operation is accepted.
   int          mLeft;
   logic [31:0] mHi, mLo, pHi, pLo;
   bit          pValid;
   longint      sa, sb, prod, quo, rem;

   initial begin
      mLeft  = 0;
      mHi    = 0;
      mLo    = 0;
      pHi    = 0;
      pLo    = 0;
      pValid = 0;
   end

   always @(posedge clk) begin
      if (rst) begin
         mLeft  = 0;
         mHi    = 0;
         mLo    = 0;
         pValid = 0;
      end else if (mLeft > 0) begin
         mLeft = mLeft - 1;
         if (mLeft == 0 && pValid) begin
            mHi = pHi;
            mLo = pLo;
         end
      end else if (bus.start && (bus.mult_E || bus.div_E)) begin
         sa = longint'($signed(bus.rs_E));
         sb = longint'($signed(bus.rt_E));
         if (bus.mult_E) begin
            prod   = sa * sb;
            pHi    = prod[63:32];
            pLo    = prod[31:0];
            pValid = 1;
            mLeft  = MULT_CYC;
         end else begin
            pValid = (sb != 0);
            if (sb != 0) begin
               quo = sa / sb;
               rem = sa % sb;
               pHi = rem[31:0];
               pLo = quo[31:0];
            end
            mLeft = DIV_CYC;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic st, input logic m, input logic d,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic rdHi, input logic mdD);
      bus.start  = st;
      bus.mult_E = m;
      bus.div_E  = d;
      bus.rs_E   = a;
      bus.rt_E   = b;
      bus.mfhi_E = rdHi;
      bus.mflo_E = ~rdHi;
      bus.md_D   = mdD;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         applyStimulus(0, 0, 0, 32'd0, 32'd0, 0, 0);
         tick();
      end
   endtask

   // Launch one operation, then count busy cycles (bounded).
   task automatic runOp(input logic m, input logic d, input logic [31:0] a,
                        input logic [31:0] b, output int cycles);
      applyStimulus(1, m, d, a, b, 0, 0);
      tick();
      cycles = 0;
      while (bus.busy && cycles < 200) begin
         applyStimulus(0, 0, 0, 32'd0, 32'd0, 0, 0);
         tick();
         cycles++;
      end
   endtask

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(5))
         0:       return 32'd0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($signed($urandom_range(40)) - 20);
         default: return $urandom;
      endcase
   endfunction

   typedef struct {
      string       name;
      logic        isMult;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] expHi;
      logic [31:0] expLo;
      int          expBusy;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int cyc;
      logic st, m, d, rdHi, mdD;
      logic [31:0] a, b;

      errors = 0;
      checks = 0;

      vecs[0] = '{"mul_m1x2",    1'b1, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFE, MULT_CYC};
      vecs[1] = '{"div_m7d2",    1'b0, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_CYC};
      vecs[2] = '{"div_7dm2",    1'b0, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, DIV_CYC};
      vecs[3] = '{"div_m7dm2",   1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3,        DIV_CYC};
      vecs[4] = '{"div_ovf",     1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, DIV_CYC};
      vecs[5] = '{"mul_minsq",   1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,        MULT_CYC};
      vecs[6] = '{"mul_shift",   1'b1, 32'h1234_5678, 32'h10,        32'd1,        32'h2345_6780, MULT_CYC};
      vecs[7] = '{"div_100d7",   1'b0, 32'd100,       32'd7,         32'd2,        32'd14,        DIV_CYC};
      vecs[8] = '{"mul_maxsq",   1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, MULT_CYC};

      // Reset state
      rst = 1;
      applyStimulus(0, 0, 0, 32'd0, 32'd0, 0, 0);
      tick();
      tick();
      rst = 0;
      checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
      checkOutput("reset_hi", bus.hi, 32'd0);
      checkOutput("reset_lo", bus.lo, 32'd0);

      // Directed vectors
      for (int i = 0; i < 9; i++) begin
         runOp(vecs[i].isMult, ~vecs[i].isMult, vecs[i].a, vecs[i].b, cyc);
         checkOutput({vecs[i].name, "_cycles"}, cyc, vecs[i].expBusy);
         checkOutput({vecs[i].name, "_hi"}, bus.hi, vecs[i].expHi);
         checkOutput({vecs[i].name, "_lo"}, bus.lo, vecs[i].expLo);
         idle(1);
      end

      // Divide by zero after 3*4 keeps hi/lo but still takes the full time
      runOp(1, 0, 32'd3, 32'd4, cyc);
      runOp(0, 1, 32'd5, 32'd0, cyc);
      checkOutput("div0_cycles", cyc, DIV_CYC);
      checkOutput("div0_hi", bus.hi, 32'd0);
      checkOutput("div0_lo", bus.lo, 32'd12);

      // Start with neither op selected does nothing
      applyStimulus(1, 0, 0, 32'd9, 32'd9, 0, 0);
      tick();
      checkOutput("nop_busy", {31'd0, bus.busy}, 32'd0);
      checkOutput("nop_lo", bus.lo, 32'd12);

      // mult wins when both selects are set
      runOp(1, 1, 32'd6, 32'hFFFF_FFFF, cyc);
      checkOutput("both_cycles", cyc, MULT_CYC);
      checkOutput("both_hi", bus.hi, 32'hFFFF_FFFF);
      checkOutput("both_lo", bus.lo, 32'hFFFF_FFFA);

      // Stall while a mult is launched and in flight; md_out shows old values
      for (int c = 0; c <= MULT_CYC + 1; c++) begin
         applyStimulus(c == 0, c == 0, 0, 32'd3, 32'd5, c[0], c <= MULT_CYC);
         #1;
         checkOutput($sformatf("stall_c%0d", c), {31'd0, bus.stall_md}, {31'd0, c <= MULT_CYC});
         if (c >= 1 && c <= MULT_CYC)
            checkOutput($sformatf("mdout_c%0d", c), bus.md_out, c[0] ? 32'hFFFF_FFFF : 32'hFFFF_FFFA);
         tick();
      end
      checkOutput("stallseq_lo", bus.lo, 32'd15);
      applyStimulus(0, 0, 0, 32'd0, 32'd0, 1, 0);
      #1;
      checkOutput("mdout_hi", bus.md_out, 32'd0);

      // Reset at cycle N+3 of a div aborts it
      applyStimulus(1, 0, 1, 32'd100, 32'd7, 0, 0);
      tick();
      idle(2);
      rst = 1;
      applyStimulus(1, 1, 0, 32'd2, 32'd2, 0, 0);
      tick();
      rst = 0;
      checkOutput("abort_busy", {31'd0, bus.busy}, 32'd0);
      checkOutput("abort_hi", bus.hi, 32'd0);
      checkOutput("abort_lo", bus.lo, 32'd0);
      idle(DIV_CYC + 3);
      checkOutput("abort_late_hi", bus.hi, 32'd0);
      checkOutput("abort_late_lo", bus.lo, 32'd0);

      // Start while busy is ignored
      applyStimulus(1, 1, 0, 32'd3, 32'd5, 0, 0);
      tick();
      applyStimulus(1, 1, 0, 32'd7, 32'd9, 0, 0);
      tick();
      applyStimulus(1, 0, 1, 32'd40, 32'd3, 0, 0);
      tick();
      idle(MULT_CYC - 2);
      checkOutput("ignore_busy", {31'd0, bus.busy}, 32'd0);
      checkOutput("ignore_hi", bus.hi, 32'd0);
      checkOutput("ignore_lo", bus.lo, 32'd15);
      idle(DIV_CYC);
      checkOutput("ignore_late_lo", bus.lo, 32'd15);

      // Randomized run against the reference model
      for (int n = 0; n < 400; n++) begin
         checkOutput("rnd_busy", {31'd0, bus.busy}, {31'd0, mLeft > 0});
         checkOutput("rnd_hi", bus.hi, mHi);
         checkOutput("rnd_lo", bus.lo, mLo);
         rst  = ($urandom_range(63) == 0);
         st   = ($urandom_range(2) == 0);
         m    = $urandom_range(1);
         d    = $urandom_range(1);
         rdHi = $urandom_range(1);
         mdD  = $urandom_range(1);
         a    = pickOperand();
         b    = pickOperand();
         applyStimulus(st, m, d, a, b, rdHi, mdD);
         #1;
         checkOutput("rnd_stall", {31'd0, bus.stall_md}, {31'd0, mdD & ((mLeft > 0) | st)});
         checkOutput("rnd_mdout", bus.md_out, rdHi ? mHi : mLo);
         tick();
      end
      rst = 0;
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
